// File: rtl/spi_tx.sv
// spi_tx: parallel-to-serial transmitter for the R2R DAC serial link.
// Accepts D_W-bit words over a valid/ready handshake into a one-word holding
// register, then shifts each word out MSB-first, one bit per clk, with frame
// high during data bits, followed by GAP_CYCLES idle cycles (done pulses in
// the last one). Back-to-back words need no extra idle cycle.
//
// Optional feature: define SPI_TX_PARITY_EN to append one even-parity bit
// (XOR of the word) after the data bits, inside the frame.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   din        parallel word to transmit
//   din_valid  din holds a valid word
//   din_ready  holding register empty (accept when din_valid && din_ready)
//   serial_out serial data, registered, 0 whenever frame is low
//   frame      high while a data/parity bit is on serial_out, registered
//   busy       shifter active or holding register full
//   done       one-cycle pulse in the last gap cycle of each word
module spi_tx #(
    parameter int unsigned D_W        = 8,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [D_W-1:0] din,
    input  logic           din_valid,
    output logic           din_ready,
    output logic           serial_out,
    output logic           frame,
    output logic           busy,
    output logic           done
);

`ifdef SPI_TX_PARITY_EN
    localparam int unsigned NBITS = D_W + 1;
`else
    localparam int unsigned NBITS = D_W;
`endif
    localparam int unsigned CNT_W = $clog2(NBITS);
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             state;
    logic [D_W-1:0]     hold;
    logic               hold_full;
    logic [NBITS-1:0]   shreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    // Bits of one frame, first-out bit at the MSB.
    function automatic logic [NBITS-1:0] frame_word(input logic [D_W-1:0] w);
`ifdef SPI_TX_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    // The shifter MSB is the line; it drains to all-zero on the final shift,
    // so the line is low in IDLE and GAP without extra muxing.
    assign serial_out = shreg[NBITS-1];
    assign din_ready  = !hold_full;
    assign busy       = (state != ST_IDLE) || hold_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            frame     <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Accept and load never coincide: one needs hold empty, the other full.
            if (din_valid && !hold_full) begin
                hold      <= din;
                hold_full <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (hold_full) begin
                        shreg     <= frame_word(hold);
                        hold_full <= 1'b0;
                        bit_cnt   <= '0;
                        frame     <= 1'b1;
                        state     <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    shreg <= {shreg[NBITS-2:0], 1'b0};
                    if (bit_cnt == CNT_W'(NBITS - 1)) begin
                        frame   <= 1'b0;
                        gap_cnt <= '0;
                        done    <= (GAP_CYCLES == 1);
                        state   <= ST_GAP;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        done <= 1'b0;
                        if (hold_full) begin
                            shreg     <= frame_word(hold);
                            hold_full <= 1'b0;
                            bit_cnt   <= '0;
                            frame     <= 1'b1;
                            state     <= ST_SHIFT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                        done    <= ((gap_cnt + GAP_W'(1)) == GAP_W'(GAP_CYCLES - 1));
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    frame <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_tx.sv
// Testbench for spi_tx: table-driven single-word frames plus hand-written
// back-to-back, stall, mid-frame reset and long-gap sequences.
module tb_spi_tx;

`ifdef SPI_TX_PARITY_EN
    localparam int  NB  = 9;
    localparam bit  PAR = 1'b1;
`else
    localparam int  NB  = 8;
    localparam bit  PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       v1, v3;
    logic       r1, s1, f1, b1, d1;
    logic       r3, s3, f3, b3, d3;

    always #5 clk = ~clk;

    spi_tx #(.D_W(8), .GAP_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .din(din), .din_valid(v1), .din_ready(r1),
        .serial_out(s1), .frame(f1), .busy(b1), .done(d1)
    );

    spi_tx #(.D_W(8), .GAP_CYCLES(3)) u3 (
        .clk(clk), .rst(rst), .din(din), .din_valid(v3), .din_ready(r3),
        .serial_out(s3), .frame(f3), .busy(b3), .done(d3)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] word;
        logic [7:0] bits;   // expected line, first bit at [7]
        logic       par;    // expected even-parity bit
    } vec_t;

    vec_t vt[6];

    // Single word on u1 from idle, checked cycle by cycle.
    task automatic send_single(input vec_t v);
        int t = 0;
        while (!r1 && t < 50) begin
            tick();
            t++;
        end
        check("ready_before_send", 32'(r1), 32'd1);
        din = v.word;
        v1  = 1'b1;
        tick();                         // accept edge k
        v1  = 1'b0;
        din = ~v.word;                  // must not disturb the held word
        check("after_accept {ready,busy,frame}", {29'd0, r1, b1, f1}, 32'b010);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("w%02h bit%0d {s,f,d}", v.word, i),
                  {29'd0, s1, f1, d1}, {29'd0, v.bits[7-i], 1'b1, 1'b0});
        end
        if (PAR) begin
            tick();
            check($sformatf("w%02h parity {s,f,d}", v.word),
                  {29'd0, s1, f1, d1}, {29'd0, v.par, 1'b1, 1'b0});
        end
        tick();
        check($sformatf("w%02h gap {s,f,d}", v.word), {29'd0, s1, f1, d1}, 32'b001);
        tick();
        check($sformatf("w%02h idle {busy,done,ready}", v.word), {29'd0, b1, d1, r1}, 32'b001);
    endtask

    // Continuously valid source of n words on instance sel (1 or 3); records
    // accept cycles, frame starts, done pulses and line bits, then compares.
    task automatic run_stream(input int sel, input int gap, input logic [7:0] w[3], input int n);
        int          idx = 0;
        int          per = NB + gap;
        int          acc_c[$];
        int          start_c[$];
        int          done_c[$];
        logic        bits[$];
        logic        acc, prev_f, rdy, sv, fv, dv;
        int          bad_idle = 0;
        logic [8:0]  got, exp;
        int          exp_acc;
        prev_f = 1'b0;
        din = w[0];
        if (sel == 3) v3 = 1'b1; else v1 = 1'b1;
        for (int cyc = 0; cyc < n * per + 6; cyc++) begin
            acc = (sel == 3) ? (v3 && r3) : (v1 && r1);
            tick();
            if (acc) begin
                acc_c.push_back(cyc);
                idx++;
            end
            rdy = (sel == 3) ? r3 : r1;
            sv  = (sel == 3) ? s3 : s1;
            fv  = (sel == 3) ? f3 : f1;
            dv  = (sel == 3) ? d3 : d1;
            // While stalled, wiggle din: it must be ignored.
            din = (idx < n) ? (rdy ? w[idx] : ~w[idx]) : 8'h00;
            if (sel == 3) v3 = (idx < n); else v1 = (idx < n);
            if (fv && !prev_f) start_c.push_back(cyc);
            if (fv) bits.push_back(sv);
            else if (sv) bad_idle++;
            if (dv) done_c.push_back(cyc);
            prev_f = fv;
        end
        check($sformatf("g%0d accept count", gap), 32'(acc_c.size()), 32'(n));
        for (int i = 0; i < n && i < acc_c.size(); i++) begin
            exp_acc = (i == 0) ? 0 : (i == 1) ? 2 : per + 2;
            check($sformatf("g%0d accept cycle %0d", gap, i), 32'(acc_c[i]), 32'(exp_acc));
        end
        check($sformatf("g%0d frame count", gap), 32'(start_c.size()), 32'(n));
        for (int i = 0; i < n && i < start_c.size(); i++)
            check($sformatf("g%0d frame start %0d", gap, i), 32'(start_c[i]), 32'(1 + i * per));
        check($sformatf("g%0d done count", gap), 32'(done_c.size()), 32'(n));
        for (int i = 0; i < n && i < done_c.size(); i++)
            check($sformatf("g%0d done cycle %0d", gap, i), 32'(done_c[i]), 32'(i * per + per));
        check($sformatf("g%0d bit count", gap), 32'(bits.size()), 32'(n * NB));
        if (bits.size() == n * NB) begin
            for (int i = 0; i < n; i++) begin
                got = '0;
                for (int b = 0; b < NB; b++) got = {got[7:0], bits[i * NB + b]};
                exp = PAR ? {w[i], ^w[i]} : {1'b0, w[i]};
                check($sformatf("g%0d word %0d", gap, i), 32'(got), 32'(exp));
            end
        end
        check($sformatf("g%0d line low outside frame", gap), 32'(bad_idle), 32'd0);
        check($sformatf("g%0d final busy", gap), 32'((sel == 3) ? b3 : b1), 32'd0);
    endtask

    initial begin
        vt[0] = '{8'hA5, 8'b10100101, 1'b0};
        vt[1] = '{8'h07, 8'b00000111, 1'b1};
        vt[2] = '{8'h03, 8'b00000011, 1'b0};
        vt[3] = '{8'hF0, 8'b11110000, 1'b0};
        vt[4] = '{8'h80, 8'b10000000, 1'b1};
        vt[5] = '{8'hFF, 8'b11111111, 1'b0};

        rst = 1'b1;
        v1  = 1'b0;
        v3  = 1'b0;
        din = 8'h00;
        #2;
        check("reset u1 {s,f,d,ready,busy}", {27'd0, s1, f1, d1, r1, b1}, 32'b00010);
        check("reset u3 {s,f,d,ready,busy}", {27'd0, s3, f3, d3, r3, b3}, 32'b00010);
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 6; i++) send_single(vt[i]);

        run_stream(1, 1, '{8'h3C, 8'hC3, 8'h00}, 2);
        tick();
        run_stream(1, 1, '{8'h81, 8'h5A, 8'hE7}, 3);
        tick();

        // Mid-frame reset with a second word held.
        din = 8'hF0;
        v1  = 1'b1;
        tick();                         // accept F0
        din = 8'h55;
        tick();                         // load F0, bit 0 out
        tick();                         // accept 55, bit 1 out
        v1 = 1'b0;
        tick();
        tick();                         // bit 3 of F0 on line
        check("pre-reset {s,f,busy,ready}", {28'd0, s1, f1, b1, r1}, 32'b1110);
        rst = 1'b1;
        #1;
        check("async reset {s,f,d,ready,busy}", {27'd0, s1, f1, d1, r1, b1}, 32'b00010);
        tick();
        rst = 1'b0;
        begin
            int fhigh = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (f1 || b1) fhigh++;
            end
            check("held word discarded", 32'(fhigh), 32'd0);
        end
        send_single(vt[0]);

        run_stream(3, 3, '{8'h96, 8'h69, 8'h00}, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
